lcd_string_driver: RTL and testbench
====================================

// Module: lcd_string_driver
// PURPOSE
//  Downstream LCD stage: takes the 32-character ASCII frame from the ALU top and drives a
//  2x16 HD44780-class character LCD in 4-bit, write-only mode. Runs power-up init, then
//  rewrites the full frame on each refresh pulse. Owns all LCD pin timing; the ALU top only
//  updates strdata and pulses refresh.
// PARAMETERS
//  T_PWRUP    750000  cycles of wait after reset before the first init nibble (15 ms @50 MHz)
//  T_INIT     205000  cycles of wait after each of the three 0x3 init nibbles (4.1 ms)
//  T_E_HIGH   12      cycles LCDE is held high per nibble (>=230 ns)
//  T_NIB      50      cycles of gap after a nibble's E falls, before the next nibble (1 us)
//  T_CMD      2000    cycles of gap after a full byte (40 us)
//  T_CLR      82000   cycles of gap after the clear command 0x01 (1.64 ms)
// PORTS
//  CCLK     in   1    system clock, all state on its rising edge
//  rst_n    in   1    asynchronous, active-low reset
//  refresh  in   1    one-cycle pulse: rewrite the LCD from strdata
//  strdata  in   256  frame, char0=[255:248] ... char31=[7:0]; line1=chars0-15, line2=16-31
//  busy     out  1    high from reset until idle, and during any frame write
//  init_done out 1    high once the init sequence completes; stays high until reset
//  LCDRS    out  1    0=command, 1=data
//  LCDRW    out  1    constant 0 (write only)
//  LCDE     out  1    enable strobe
//  LCDDAT   out  4    data nibble, high nibble sent first
// BEHAVIOUR
//  - Reset (async, any state): LCDE=0, LCDRS=0, LCDRW=0, LCDDAT=0, init_done=0, busy=1,
//    pending=0. FSM goes to PWR_WAIT and the timer clears. Mid-frame reset abandons the
//    frame and restarts the full init sequence.
//  - FSM: PWR_WAIT -> INIT3 (nibble 0x3, 3 times, each followed by T_INIT) -> INIT2 (nibble
//    0x2, T_CMD) -> CFG (bytes 0x28, 0x06, 0x0C with T_CMD each, then 0x01 with T_CLR) ->
//    FRAME -> IDLE.
//  - FRAME: 0x80 (cmd), 16 data bytes, 0xC0 (cmd), 16 data bytes. Each byte gets T_CMD.
//    strdata is snapshotted into a frame register on the cycle FRAME is entered. Later
//    changes to strdata do not affect the frame in progress.
//  - Nibble timing: LCDRS/LCDDAT valid 1 cycle before LCDE rises; LCDE high T_E_HIGH
//    cycles; LCDRS/LCDDAT held 1 cycle after LCDE falls; then a T_NIB gap.
//  - First FRAME after CFG runs automatically; init_done rises on the cycle CFG ends.
//  - IDLE: busy=0, LCDE=0. refresh=1 in IDLE -> FRAME next cycle, busy=1 the same edge.
//  - refresh while busy (init or frame): set pending. At frame end, if pending, clear it,
//    re-snapshot, and start FRAME again with no IDLE cycle. Multiple pulses merge into one.
//  - refresh on the same cycle a frame ends: treated as pending (one more frame).
//  - Timers are 20-bit down counters. A parameter value of 0 is treated as 1 cycle.
//  - Latency: refresh in IDLE -> first LCDE rise = 2 cycles.
// STRUCTURE
//  - Package lcd_pkg: command constants (LCD_FUNC_4BIT2L=8'h28, LCD_ENTRY_INC=8'h06,
//    LCD_DISP_ON=8'h0C, LCD_CLEAR=8'h01, LCD_LINE1=8'h80, LCD_LINE2=8'hC0) and the FSM
//    state encoding.
//  - Sub-module lcd_byte_tx: start/done handshake. Takes {rs, byte, single_nibble, gap};
//    generates nibble E timing and the post-byte gap; done pulses 1 cycle at the end.
//    The top FSM handles sequencing and the character index (5-bit, 0..31).
// TESTING (bench overrides: T_PWRUP=100, T_INIT=40, T_E_HIGH=2, T_NIB=3, T_CMD=10, T_CLR=30)
//  1 reset, strdata="1111 2222" space-padded -> nibble trace 3,3,3,2,(2,8),(0,6),(0,C),(0,1);
//    then (8,0),'1','1','1','1',' ','2'... (C,0); init_done=1 after 0x01; busy=0 at end.
//  2 idle, strdata line2 = "ABCD", refresh pulse -> LCDE rises 2 cycles later; RS=1 bytes
//    41,42,43,44 follow 0xC0; total LCDE pulses per frame = 68.
//  3 three refresh pulses during a frame -> exactly one extra frame, no IDLE cycle between.
//  4 rst_n low at char 20 of a frame -> all outputs 0 immediately; busy=1; init restarts
//    with PWR_WAIT and no stray LCDE pulse.
//  5 strdata changed mid-frame -> remaining chars still come from the old snapshot.
//  6 timing check: every nibble has RS/DAT stable from 1 cycle before E rises to 1 cycle
//    after E falls; LCDRW never 1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared command bytes, FSM encodings and timer helper for the 4-bit HD44780 string driver.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_4BIT2L = 8'h28;
    localparam logic [7:0] LCD_ENTRY_INC   = 8'h06;
    localparam logic [7:0] LCD_DISP_ON     = 8'h0C;
    localparam logic [7:0] LCD_CLEAR       = 8'h01;
    localparam logic [7:0] LCD_LINE1       = 8'h80;
    localparam logic [7:0] LCD_LINE2       = 8'hC0;
    // Init nibbles travel in the high half of the byte, which is the half sent first.
    localparam logic [7:0] LCD_NIB_3       = 8'h30;
    localparam logic [7:0] LCD_NIB_2       = 8'h20;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT3,
        ST_INIT2,
        ST_CFG,
        ST_FRAME,
        ST_IDLE
    } lcd_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_EHI,
        TX_HOLD,
        TX_GAP
    } tx_state_e;

    // Down-counter reload value for a wait of t cycles; zero is treated as one cycle.
    function automatic logic [19:0] cyc_m1(input logic [19:0] t);
        return (t == 20'd0) ? 20'd0 : t - 20'd1;
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Sends one byte (or one high nibble) to the LCD with setup/E/hold timing, then waits the
// caller-supplied gap. start is accepted only while idle_o; done_o pulses on the last gap cycle.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int unsigned T_E_HIGH = 12,
    parameter int unsigned T_NIB    = 50
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        rs_i,
    input  logic [7:0]  data_i,
    input  logic        single_i,
    input  logic [19:0] gap_i,
    output logic        idle_o,
    output logic        done_o,
    output logic        lcd_e_o,
    output logic        lcd_rs_o,
    output logic [3:0]  lcd_dat_o
);

    tx_state_e   state_q, state_d;
    logic [19:0] tmr_q, tmr_d;
    logic [19:0] gap_q, gap_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        single_q, single_d;
    logic        low_q, low_d;
    logic        last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= TX_IDLE;
            tmr_q    <= 20'd0;
            gap_q    <= 20'd0;
            data_q   <= 8'd0;
            rs_q     <= 1'b0;
            single_q <= 1'b0;
            low_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            single_q <= single_d;
            low_q    <= low_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        gap_d    = gap_q;
        data_d   = data_q;
        rs_d     = rs_q;
        single_d = single_q;
        low_d    = low_q;
        done_o   = 1'b0;
        last     = low_q | single_q;
        case (state_q)
            TX_IDLE: begin
                if (start_i) begin
                    rs_d     = rs_i;
                    data_d   = data_i;
                    single_d = single_i;
                    gap_d    = cyc_m1(gap_i);
                    low_d    = 1'b0;
                    state_d  = TX_SETUP;
                end
            end
            TX_SETUP: begin
                tmr_d   = cyc_m1(20'(T_E_HIGH));
                state_d = TX_EHI;
            end
            TX_EHI: begin
                if (tmr_q == 20'd0) state_d = TX_HOLD;
                else                tmr_d   = tmr_q - 20'd1;
            end
            TX_HOLD: begin
                // The final nibble of a transfer waits the byte gap instead of the nibble gap.
                tmr_d   = last ? gap_q : cyc_m1(20'(T_NIB));
                state_d = TX_GAP;
            end
            TX_GAP: begin
                if (tmr_q != 20'd0) begin
                    tmr_d = tmr_q - 20'd1;
                end else if (last) begin
                    done_o  = 1'b1;
                    state_d = TX_IDLE;
                end else begin
                    low_d   = 1'b1;
                    state_d = TX_SETUP;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign idle_o    = (state_q == TX_IDLE);
    assign lcd_e_o   = (state_q == TX_EHI);
    assign lcd_rs_o  = rs_q;
    assign lcd_dat_o = low_q ? data_q[3:0] : data_q[7:4];

endmodule

// File: rtl/lcd_string_driver.sv
// Power-up init and full 32-character frame writes to a 2x16 character LCD in 4-bit mode.
// Refresh requests arriving while busy collapse into one follow-on frame.
module lcd_string_driver
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP  = 750000,
    parameter int unsigned T_INIT   = 205000,
    parameter int unsigned T_E_HIGH = 12,
    parameter int unsigned T_NIB    = 50,
    parameter int unsigned T_CMD    = 2000,
    parameter int unsigned T_CLR    = 82000
) (
    input  logic         CCLK,
    input  logic         rst_n,
    input  logic         refresh,
    input  logic [255:0] strdata,
    output logic         busy,
    output logic         init_done,
    output logic         LCDRS,
    output logic         LCDRW,
    output logic         LCDE,
    output logic [3:0]   LCDDAT
);

    lcd_state_e   state_q, state_d;
    logic [19:0]  tmr_q, tmr_d;
    logic         arm_q, arm_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [4:0]   idx_q, idx_d;
    logic         line_q, line_d;
    logic         pend_q, pend_d;
    logic         init_done_q, init_done_d;
    logic [255:0] frame_q;

    logic         snap;
    logic         tx_start, tx_rs, tx_single, tx_idle, tx_done;
    logic [7:0]   tx_data;
    logic [19:0]  tx_gap;

    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWR_WAIT;
            tmr_q       <= 20'd0;
            arm_q       <= 1'b0;
            cnt_q       <= 2'd0;
            idx_q       <= 5'd0;
            line_q      <= 1'b0;
            pend_q      <= 1'b0;
            init_done_q <= 1'b0;
            frame_q     <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            arm_q       <= arm_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            line_q      <= line_d;
            pend_q      <= pend_d;
            init_done_q <= init_done_d;
            if (snap) frame_q <= strdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        arm_d       = arm_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        line_d      = line_q;
        pend_d      = pend_q | (refresh & (state_q != ST_IDLE));
        init_done_d = init_done_q;
        snap        = 1'b0;
        tx_start    = 1'b0;
        tx_rs       = 1'b0;
        tx_data     = 8'd0;
        tx_single   = 1'b0;
        tx_gap      = 20'(T_CMD);
        case (state_q)
            ST_PWR_WAIT: begin
                // First cycle after reset loads the timer from its cleared value.
                if (!arm_q) begin
                    arm_d = 1'b1;
                    tmr_d = cyc_m1(20'(T_PWRUP));
                end else if (tmr_q == 20'd0) begin
                    cnt_d   = 2'd0;
                    state_d = ST_INIT3;
                end else begin
                    tmr_d = tmr_q - 20'd1;
                end
            end
            ST_INIT3: begin
                tx_start  = tx_idle;
                tx_data   = LCD_NIB_3;
                tx_single = 1'b1;
                tx_gap    = 20'(T_INIT);
                if (tx_done) begin
                    if (cnt_q == 2'd2) state_d = ST_INIT2;
                    else               cnt_d   = cnt_q + 2'd1;
                end
            end
            ST_INIT2: begin
                tx_start  = tx_idle;
                tx_data   = LCD_NIB_2;
                tx_single = 1'b1;
                if (tx_done) begin
                    cnt_d   = 2'd0;
                    state_d = ST_CFG;
                end
            end
            ST_CFG: begin
                tx_start = tx_idle;
                case (cnt_q)
                    2'd0:    tx_data = LCD_FUNC_4BIT2L;
                    2'd1:    tx_data = LCD_ENTRY_INC;
                    2'd2:    tx_data = LCD_DISP_ON;
                    default: tx_data = LCD_CLEAR;
                endcase
                if (cnt_q == 2'd3) tx_gap = 20'(T_CLR);
                if (tx_done) begin
                    if (cnt_q == 2'd3) begin
                        init_done_d = 1'b1;
                        snap        = 1'b1;
                        idx_d       = 5'd0;
                        line_d      = 1'b1;
                        state_d     = ST_FRAME;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ST_FRAME: begin
                tx_start = tx_idle;
                // Char idx lives at bits [8*(31-idx) +: 8]; 31-idx is ~idx for a 5-bit index.
                tx_rs    = ~line_q;
                tx_data  = line_q ? (idx_q[4] ? LCD_LINE2 : LCD_LINE1)
                                  : frame_q[{~idx_q, 3'b000} +: 8];
                if (tx_done) begin
                    if (line_q) begin
                        line_d = 1'b0;
                    end else if (idx_q == 5'd31) begin
                        if (pend_q | refresh) begin
                            pend_d = 1'b0;
                            snap   = 1'b1;
                            idx_d  = 5'd0;
                            line_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                        if (idx_q == 5'd15) line_d = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (refresh) begin
                    snap    = 1'b1;
                    idx_d   = 5'd0;
                    line_d  = 1'b1;
                    state_d = ST_FRAME;
                end
            end
            default: state_d = ST_PWR_WAIT;
        endcase
    end

    lcd_byte_tx #(
        .T_E_HIGH (T_E_HIGH),
        .T_NIB    (T_NIB)
    ) u_tx (
        .clk_i     (CCLK),
        .rst_ni    (rst_n),
        .start_i   (tx_start),
        .rs_i      (tx_rs),
        .data_i    (tx_data),
        .single_i  (tx_single),
        .gap_i     (tx_gap),
        .idle_o    (tx_idle),
        .done_o    (tx_done),
        .lcd_e_o   (LCDE),
        .lcd_rs_o  (LCDRS),
        .lcd_dat_o (LCDDAT)
    );

    assign busy      = (state_q != ST_IDLE);
    assign init_done = init_done_q;
    assign LCDRW     = 1'b0;

endmodule

// File: tb/tb_lcd_string_driver.sv
// Directed bench for lcd_string_driver: expected {rs,nibble} pairs are queued as stimulus is
// applied and checked against every LCDE rising edge, alongside strobe timing checks.
module tb_lcd_string_driver;

    localparam int unsigned P_E_HIGH = 2;

    logic         CCLK = 1'b0;
    logic         rst_n;
    logic         refresh;
    logic [255:0] strdata;
    logic         busy, init_done, LCDRS, LCDRW, LCDE;
    logic [3:0]   LCDDAT;

    int n_vec = 0;
    int n_err = 0;
    int rise_cnt = 0;
    int idle_cnt = 0;
    int hi_cnt = 0;

    logic [4:0] exp_q[$];
    logic [4:0] exp_nib;
    logic       e_prev = 1'b0;
    logic       rs_prev = 1'b0;
    logic [3:0] dat_prev = 4'd0;
    logic       rs_hold = 1'b0;
    logic [3:0] dat_hold = 4'd0;

    lcd_string_driver #(
        .T_PWRUP  (100),
        .T_INIT   (40),
        .T_E_HIGH (P_E_HIGH),
        .T_NIB    (3),
        .T_CMD    (10),
        .T_CLR    (30)
    ) dut (
        .CCLK      (CCLK),
        .rst_n     (rst_n),
        .refresh   (refresh),
        .strdata   (strdata),
        .busy      (busy),
        .init_done (init_done),
        .LCDRS     (LCDRS),
        .LCDRW     (LCDRW),
        .LCDE      (LCDE),
        .LCDDAT    (LCDDAT)
    );

    // clock / reset
    always #5 CCLK = ~CCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard drivers
    task automatic push_nib(input logic rs, input logic [3:0] nib);
        exp_q.push_back({rs, nib});
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        push_nib(rs, b[7:4]);
        push_nib(rs, b[3:0]);
    endtask

    task automatic push_init();
        for (int i = 0; i < 3; i++) push_nib(1'b0, 4'h3);
        push_nib(1'b0, 4'h2);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endtask

    task automatic push_frame(input logic [255:0] f);
        push_byte(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) push_byte(1'b1, f[8*(31-i) +: 8]);
        push_byte(1'b0, 8'hC0);
        for (int i = 16; i < 32; i++) push_byte(1'b1, f[8*(31-i) +: 8]);
    endtask

    function automatic logic [255:0] make_frame(input string l1, input string l2);
        logic [255:0] f;
        f = {32{8'h20}};
        for (int i = 0; i < 16; i++) begin
            if (i < l1.len()) f[8*(31-i) +: 8] = l1[i];
            if (i < l2.len()) f[8*(15-i) +: 8] = l2[i];
        end
        return f;
    endfunction

    task automatic pulse_refresh();
        @(posedge CCLK); #1 refresh = 1'b1;
        @(posedge CCLK); #1 refresh = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(posedge CCLK); #1;
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_q(input string tag, input int target, input int max);
        int n;
        n = 0;
        while (exp_q.size() > target && n < max) begin
            @(posedge CCLK); #1;
            n++;
        end
        check(tag, 32'(exp_q.size() <= target), 32'd1);
    endtask

    // monitor: pops the scoreboard on every LCDE rise and checks setup/width/hold
    always @(negedge CCLK) begin
        if (!rst_n) begin
            e_prev = 1'b0;
            hi_cnt = 0;
        end else begin
            if (LCDE && !e_prev) begin
                rise_cnt++;
                hi_cnt = 1;
                check("setup", {27'd0, LCDRS, LCDDAT}, {27'd0, rs_prev, dat_prev});
                check("lcdrw", 32'(LCDRW), 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL nibble: observed rs=%0d dat=%0h expected no pulse", LCDRS, LCDDAT);
                end else begin
                    exp_nib = exp_q.pop_front();
                    check("nibble", {27'd0, LCDRS, LCDDAT}, {27'd0, exp_nib});
                end
                rs_hold  = LCDRS;
                dat_hold = LCDDAT;
            end else if (LCDE) begin
                hi_cnt++;
                check("stable", {27'd0, LCDRS, LCDDAT}, {27'd0, rs_hold, dat_hold});
            end else if (e_prev) begin
                check("e_width", 32'(hi_cnt), 32'(P_E_HIGH));
                check("hold", {27'd0, LCDRS, LCDDAT}, {27'd0, rs_hold, dat_hold});
            end
            if (!busy) idle_cnt++;
            e_prev   = LCDE;
            rs_prev  = LCDRS;
            dat_prev = LCDDAT;
        end
    end

    logic [255:0] f1, f2, f3, f4;

    initial begin
        f1 = make_frame("1111 2222", "");
        f2 = make_frame("HELLO", "ABCD");
        f3 = make_frame("Refresh merge", "0123456789abcdef");
        f4 = make_frame("snapshot old", "kept frame");

        // 1: reset, power-up init and the automatic first frame
        rst_n   = 1'b0;
        refresh = 1'b0;
        strdata = f1;
        repeat (3) @(posedge CCLK);
        #1;
        check("rst_lcde", 32'(LCDE), 32'd0);
        check("rst_lcdrs", 32'(LCDRS), 32'd0);
        check("rst_lcdrw", 32'(LCDRW), 32'd0);
        check("rst_lcddat", 32'(LCDDAT), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_init_done", 32'(init_done), 32'd0);
        push_init();
        push_frame(f1);
        rst_n = 1'b1;
        wait_q("init_progress", 68, 3000);
        check("init_done_before_clear_gap", 32'(init_done), 32'd0);
        wait_q("frame1_start", 67, 3000);
        check("init_done_after_cfg", 32'(init_done), 32'd1);
        check("busy_in_frame", 32'(busy), 32'd1);
        wait_idle("frame1_idle", 5000);
        check("frame1_drained", 32'(exp_q.size()), 32'd0);
        check("idle_lcde", 32'(LCDE), 32'd0);

        // 2: refresh from idle, latency and pulse count
        strdata = f2;
        push_frame(f2);
        rise_cnt = 0;
        pulse_refresh();
        check("refresh_busy", 32'(busy), 32'd1);
        check("lat_cycle1", 32'(LCDE), 32'd0);
        @(posedge CCLK); #1;
        check("lat_cycle1b", 32'(LCDE), 32'd0);
        @(posedge CCLK); #1;
        check("lat_cycle2", 32'(LCDE), 32'd1);
        wait_idle("frame2_idle", 5000);
        check("frame2_pulses", 32'(rise_cnt), 32'd68);
        check("frame2_drained", 32'(exp_q.size()), 32'd0);

        // 3: three refreshes during a frame merge into exactly one back-to-back frame
        strdata = f3;
        push_frame(f3);
        push_frame(f3);
        rise_cnt = 0;
        pulse_refresh();
        idle_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(60, 150)) @(posedge CCLK);
            pulse_refresh();
        end
        wait_q("merge_drain", 0, 6000);
        check("merge_no_idle", 32'(idle_cnt), 32'd0);
        wait_idle("merge_idle", 2000);
        check("merge_pulses", 32'(rise_cnt), 32'd136);
        repeat (300) @(posedge CCLK);
        #1;
        check("merge_no_third", 32'(rise_cnt), 32'd136);
        check("merge_stays_idle", 32'(busy), 32'd0);

        // 5: strdata changed mid-frame does not affect the frame in progress
        strdata = f4;
        push_frame(f4);
        pulse_refresh();
        wait_q("snap_mid", 40, 3000);
        strdata = f1;
        wait_idle("snap_idle", 5000);
        check("snap_drained", 32'(exp_q.size()), 32'd0);

        // 4: reset while char 20 is being written restarts the whole init sequence
        strdata = f2;
        push_frame(f2);
        pulse_refresh();
        wait_q("char20", 24, 3000);
        repeat (2) @(posedge CCLK);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_lcde", 32'(LCDE), 32'd0);
        check("mid_rst_lcdrs", 32'(LCDRS), 32'd0);
        check("mid_rst_lcddat", 32'(LCDDAT), 32'd0);
        check("mid_rst_lcdrw", 32'(LCDRW), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_init_done", 32'(init_done), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge CCLK);
        #1;
        push_init();
        push_frame(f2);
        rise_cnt = 0;
        rst_n = 1'b1;
        repeat (60) @(posedge CCLK);
        #1;
        check("pwr_wait_no_pulse", 32'(rise_cnt), 32'd0);
        wait_idle("reinit_idle", 6000);
        check("reinit_drained", 32'(exp_q.size()), 32'd0);
        check("reinit_done", 32'(init_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
